// File: rtl/majority_voter.sv
// Registered 2-of-3 majority voter with unanimity flag, one-hot dissent
// flag and a saturating count of non-unanimous votes.
module majority_voter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             cnt_clr,
  output logic             F,
  output logic             unanimous,
  output logic [2:0]       dissent,
  output logic [CNT_W-1:0] dissent_cnt
);

  logic       maj;
  logic       unan;
  logic [2:0] dis;

  // An input dissents when it differs from both of the other two.
  always_comb begin
    maj  = (A & B) | (A & C) | (B & C);
    unan = (A & B & C) | (~A & ~B & ~C);
    dis  = {(C ^ A) & (C ^ B),
            (B ^ A) & (B ^ C),
            (A ^ B) & (A ^ C)};
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      F           <= 1'b0;
      unanimous   <= 1'b0;
      dissent     <= 3'b000;
      dissent_cnt <= '0;
    end else begin
      F         <= maj;
      unanimous <= unan;
      dissent   <= dis;
      if (cnt_clr)
        dissent_cnt <= '0;
      else if (!unan && (dissent_cnt != {CNT_W{1'b1}}))
        dissent_cnt <= dissent_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_majority_voter.sv
// Scoreboard bench for majority_voter: a counting model predicts each
// cycle's outputs for an 8-bit and a 3-bit counter instance.
module tb_majority_voter;

  logic       clk = 1'b0;
  logic       rst;
  logic       A, B, C;
  logic       cnt_clr;
  logic       f8, un8, f3, un3;
  logic [2:0] dis8, dis3;
  logic [7:0] cnt8;
  logic [2:0] cnt3;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       f;
    logic       un;
    logic [2:0] dis;
    int         c8;
    int         c3;
  } exp_t;

  exp_t sb[$];
  int   m8 = 0;
  int   m3 = 0;
  int   ones;
  exp_t e_new;
  exp_t e_got;

  always #5 clk = ~clk;

  majority_voter u_dut8 (
    .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .cnt_clr(cnt_clr),
    .F(f8), .unanimous(un8), .dissent(dis8), .dissent_cnt(cnt8)
  );

  majority_voter #(.CNT_W(3)) u_dut3 (
    .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .cnt_clr(cnt_clr),
    .F(f3), .unanimous(un3), .dissent(dis3), .dissent_cnt(cnt3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: count the ones among the votes; the minority input is
  // the lone 1 (one vote high) or the lone 0 (two votes high).
  always @(posedge clk) begin
    if (rst) begin
      m8 = 0;
      m3 = 0;
      e_new = '{f: 1'b0, un: 1'b0, dis: 3'b000, c8: 0, c3: 0};
    end else begin
      ones     = int'(A) + int'(B) + int'(C);
      e_new.f  = (ones >= 2);
      e_new.un = (ones == 0) || (ones == 3);
      e_new.dis = (ones == 1) ? {C, B, A} : (ones == 2) ? ~{C, B, A} : 3'b000;
      if (cnt_clr) begin
        m8 = 0;
        m3 = 0;
      end else if (!e_new.un) begin
        if (m8 < 255) m8++;
        if (m3 < 7)   m3++;
      end
      e_new.c8 = m8;
      e_new.c3 = m3;
    end
    sb.push_back(e_new);
  end

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e_got = sb.pop_front();
      check("sb_f8",    {31'd0, f8},   {31'd0, e_got.f});
      check("sb_un8",   {31'd0, un8},  {31'd0, e_got.un});
      check("sb_dis8",  {29'd0, dis8}, {29'd0, e_got.dis});
      check("sb_cnt8",  {24'd0, cnt8}, e_got.c8);
      check("sb_f3",    {31'd0, f3},   {31'd0, e_got.f});
      check("sb_un3",   {31'd0, un3},  {31'd0, e_got.un});
      check("sb_dis3",  {29'd0, dis3}, {29'd0, e_got.dis});
      check("sb_cnt3",  {29'd0, cnt3}, e_got.c3);
    end
  end

  // Drive one vote (abc[2]=A, abc[1]=B, abc[0]=C) and return once the
  // resulting outputs are visible.
  task automatic step(input logic [2:0] abc, input logic clr);
    A       = abc[2];
    B       = abc[1];
    C       = abc[0];
    cnt_clr = clr;
    @(negedge clk);
  endtask

  logic [2:0] vec;
  logic [7:0] f_tab   = 8'b1110_1000;
  logic [2:0] dis_tab [8] = '{3'b000, 3'b100, 3'b010, 3'b001,
                              3'b001, 3'b010, 3'b100, 3'b000};

  initial begin
    rst = 1'b1;
    {A, B, C} = 3'b111;
    cnt_clr = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      step(3'b111, 1'b0);
      check("rst_f",   {31'd0, f8},   0);
      check("rst_un",  {31'd0, un8},  0);
      check("rst_dis", {29'd0, dis8}, 0);
      check("rst_cnt", {24'd0, cnt8}, 0);
    end
    rst = 1'b0;

    for (int p = 0; p < 2; p++) begin
      for (int v = 0; v < 8; v++) begin
        vec = 3'(v);
        step(vec, 1'b0);
        check("tt_f",   {31'd0, f8},   {31'd0, f_tab[v]});
        check("tt_dis", {29'd0, dis8}, {29'd0, dis_tab[v]});
        check("tt_un",  {31'd0, un8},  (v == 0 || v == 7) ? 1 : 0);
      end
      check("pass_cnt", {24'd0, cnt8}, (p == 0) ? 6 : 12);
    end

    step(3'b011, 1'b1);
    check("clr_cnt", {24'd0, cnt8}, 0);
    step(3'b011, 1'b0);
    check("after_clr_cnt", {24'd0, cnt8}, 1);

    step(3'b000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(3'b001, 1'b0);
      check("sat_cnt3", {29'd0, cnt3}, (i + 1 < 7) ? i + 1 : 7);
    end
    check("sat_cnt8", {24'd0, cnt8}, 10);

    step(3'b000, 1'b1);
    for (int i = 0; i < 5; i++) step(3'b110, 1'b0);
    check("mid_cnt5", {24'd0, cnt8}, 5);
    rst = 1'b1;
    step(3'b110, 1'b0);
    check("mid_rst_f",   {31'd0, f8},   0);
    check("mid_rst_cnt", {24'd0, cnt8}, 0);
    rst = 1'b0;
    step(3'b110, 1'b0);
    check("post_rst_f",   {31'd0, f8},   1);
    check("post_rst_cnt", {24'd0, cnt8}, 1);

    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 99) < 3);
      step(3'($urandom_range(0, 7)), ($urandom_range(0, 99) < 10));
    end
    rst = 1'b0;
    step(3'b000, 1'b0);

    #1;
    check("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
